// File: rtl/lsu_master_pkg.sv
// Shared definitions for the MEM-stage load/store initiator: op codes, FSM states,
// exception codes and small decode helpers.
package lsu_master_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  function automatic logic is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/lsu_master_if.sv
// Word-wide request/acknowledge data memory port between the LSU (master)
// and the data memory (slave).
interface lsu_master_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_master_lane.sv
// lsu_lane: combinational byte-lane logic -- store byte enables / data replication
// and load byte/half extraction with sign or zero extension.
module lsu_lane
  import lsu_master_pkg::*;
(
  input  op_e         st_op,
  input  logic [1:0]  st_addr,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  op_e         ld_op,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store steering: narrow stores are replicated so any selected lane carries the data
  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'd0;
    case (st_op)
      OP_SW: begin
        st_be   = 4'b1111;
        st_data = st_wdata;
      end
      OP_SH: begin
        st_be   = st_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{st_wdata[15:0]}};
      end
      OP_SB: begin
        st_be   = 4'b0001 << st_addr;
        st_data = {4{st_wdata[7:0]}};
      end
      default: begin
        st_be   = 4'b0000;
        st_data = 32'd0;
      end
    endcase
  end

  // Load extraction from the captured word
  always_comb begin
    half_s = ld_addr[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_addr)
      2'd0:    byte_s = ld_word[7:0];
      2'd1:    byte_s = ld_word[15:8];
      2'd2:    byte_s = ld_word[23:16];
      2'd3:    byte_s = ld_word[31:24];
      default: byte_s = 8'd0;
    endcase
    case (ld_op)
      OP_LW:   ld_data = ld_word;
      OP_LH:   ld_data = {{16{half_s[15]}}, half_s};
      OP_LHU:  ld_data = {16'd0, half_s};
      OP_LB:   ld_data = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  ld_data = {24'd0, byte_s};
      default: ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// lsu_master: MEM-stage load/store initiator with req/ack memory port and bus timeout.
// Optional alignment exceptions are built when LSU_ALIGN_CHECK_EN is defined.
module lsu_master
  import lsu_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  op_e         req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_a3,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_a3,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  lsu_master_if.master mem
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_r, state_s;
  op_e         op_r;
  logic [1:0]  addr_lo_r;
  logic [4:0]  a3_r;
  logic [7:0]  cnt_r, cnt_s;
  logic        mem_req_r, mem_req_s, mem_we_r, mem_we_s;
  logic [31:0] mem_addr_r, mem_addr_s, mem_wdata_r, mem_wdata_s;
  logic [3:0]  mem_be_r, mem_be_s;
  logic        resp_valid_r, resp_valid_s, exc_valid_r, exc_valid_s;
  logic [31:0] resp_rdata_r, resp_rdata_s;
  logic [4:0]  resp_a3_r, resp_a3_s, exc_code_r, exc_code_s;
  logic        latch_s;
  logic        align_fault_s;
  logic [3:0]  st_be_s;
  logic [31:0] st_data_s, ld_data_s;

  lsu_lane u_lane (
    .st_op    (req_op),
    .st_addr  (req_addr[1:0]),
    .st_wdata (req_wdata),
    .st_be    (st_be_s),
    .st_data  (st_data_s),
    .ld_op    (op_r),
    .ld_addr  (addr_lo_r),
    .ld_word  (mem.mem_rdata),
    .ld_data  (ld_data_s)
  );

`ifdef LSU_ALIGN_CHECK_EN
  // Natural-alignment check on the incoming request
  always_comb begin
    case (req_op)
      OP_LW, OP_SW:         align_fault_s = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: align_fault_s = req_addr[0];
      default:              align_fault_s = 1'b0;
    endcase
  end
`else
  assign align_fault_s = 1'b0;
`endif

  // Next state and next values of every registered output
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    latch_s      = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = 32'd0;
    mem_be_s     = 4'b0000;
    mem_wdata_s  = 32'd0;
    resp_valid_s = 1'b0;
    resp_rdata_s = 32'd0;
    resp_a3_s    = 5'd0;
    exc_valid_s  = 1'b0;
    exc_code_s   = EXC_NONE;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          latch_s = 1'b1;
          cnt_s   = 8'd0;
          if (align_fault_s) begin
            state_s      = ST_RESP;
            resp_valid_s = 1'b1;
            exc_valid_s  = 1'b1;
            exc_code_s   = is_store(req_op) ? EXC_ADES : EXC_ADEL;
          end else begin
            state_s     = ST_BUSY;
            mem_req_s   = 1'b1;
            mem_we_s    = is_store(req_op);
            mem_addr_s  = {req_addr[31:2], 2'b00};
            mem_be_s    = is_store(req_op) ? st_be_s : 4'b0000;
            mem_wdata_s = is_store(req_op) ? st_data_s : 32'd0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem.mem_ack) begin
          state_s      = ST_RESP;
          cnt_s        = 8'd0;
          resp_valid_s = 1'b1;
          resp_rdata_s = is_store(op_r) ? 32'd0 : ld_data_s;
          resp_a3_s    = a3_r;
        end else if (cnt_r == TO_LAST) begin
          // Memory never answered: abandon the access with a bus error
          state_s      = ST_RESP;
          cnt_s        = 8'd0;
          resp_valid_s = 1'b1;
          exc_valid_s  = 1'b1;
          exc_code_s   = EXC_DBE;
        end else begin
          cnt_s       = cnt_r + 8'd1;
          mem_req_s   = 1'b1;
          mem_we_s    = mem_we_r;
          mem_addr_s  = mem_addr_r;
          mem_be_s    = mem_be_r;
          mem_wdata_s = mem_wdata_r;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, request latches and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      op_r         <= OP_LW;
      addr_lo_r    <= 2'd0;
      a3_r         <= 5'd0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_be_r     <= 4'b0000;
      mem_wdata_r  <= 32'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_a3_r    <= 5'd0;
      exc_valid_r  <= 1'b0;
      exc_code_r   <= EXC_NONE;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      if (latch_s) begin
        op_r      <= req_op;
        addr_lo_r <= req_addr[1:0];
        a3_r      <= req_a3;
      end
      mem_req_r    <= mem_req_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_be_r     <= mem_be_s;
      mem_wdata_r  <= mem_wdata_s;
      resp_valid_r <= resp_valid_s;
      resp_rdata_r <= resp_rdata_s;
      resp_a3_r    <= resp_a3_s;
      exc_valid_r  <= exc_valid_s;
      exc_code_r   <= exc_code_s;
    end
  end

  assign stall         = ((state_r == ST_IDLE) && req_valid) || (state_r == ST_BUSY);
  assign resp_valid    = resp_valid_r;
  assign resp_rdata    = resp_rdata_r;
  assign resp_a3       = resp_a3_r;
  assign exc_valid     = exc_valid_r;
  assign exc_code      = exc_code_r;
  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_be    = mem_be_r;
  assign mem.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master: table of load/store vectors plus hand-written
// sequences for timeout, reset mid-access, stray acks and alignment faults.
module tb_lsu_master;
  import lsu_master_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  op_e         req_op = OP_LW;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_a3 = 5'd0;
  logic        stall, resp_valid, exc_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_a3, exc_code;

  lsu_master_if mif();

  lsu_master #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_a3     (req_a3),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_a3    (resp_a3),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .mem        (mif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  a3;
    int          k;
    logic [31:0] rdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    step();
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; req_a3 = v.a3;
    #1;
    chk({tag, "_stall_c0"}, 32'(stall), 32'd1);
    for (int c = 1; c <= v.k; c++) begin
      step();
      mif.mem_ack   = (c == v.k);
      mif.mem_rdata = (c == v.k) ? v.rdata : 32'h0;
      #1;
      chk($sformatf("%s_req_c%0d", tag, c), 32'(mif.mem_req), 32'd1);
      chk($sformatf("%s_stall_c%0d", tag, c), 32'(stall), 32'd1);
      chk($sformatf("%s_we_c%0d", tag, c), 32'(mif.mem_we), 32'(v.exp_we));
      chk($sformatf("%s_addr_c%0d", tag, c), mif.mem_addr, v.exp_addr);
      chk($sformatf("%s_be_c%0d", tag, c), 32'(mif.mem_be), 32'(v.exp_be));
      chk($sformatf("%s_wdata_c%0d", tag, c), mif.mem_wdata, v.exp_wdata);
      chk($sformatf("%s_early_resp_c%0d", tag, c), 32'(resp_valid), 32'd0);
    end
    step();
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0; req_valid = 1'b0;
    #1;
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_exc_valid"}, 32'(exc_valid), 32'd0);
    chk({tag, "_exc_code"}, 32'(exc_code), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, v.exp_rdata);
    chk({tag, "_a3"}, 32'(resp_a3), 32'(v.a3));
    chk({tag, "_stall_resp"}, 32'(stall), 32'd0);
    chk({tag, "_req_resp"}, 32'(mif.mem_req), 32'd0);
    step();
    chk({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
  endtask

`ifdef LSU_ALIGN_CHECK_EN
  task automatic run_fault(input op_e op, input logic [31:0] addr, input logic [4:0] code,
                           input string tag);
    step();
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = 32'hFFFF_FFFF; req_a3 = 5'd9;
    #1;
    chk({tag, "_stall_c0"}, 32'(stall), 32'd1);
    step();
    req_valid = 1'b0;
    #1;
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_exc_valid"}, 32'(exc_valid), 32'd1);
    chk({tag, "_exc_code"}, 32'(exc_code), 32'(code));
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_a3"}, 32'(resp_a3), 32'd0);
    chk({tag, "_no_req"}, 32'(mif.mem_req), 32'd0);
    chk({tag, "_stall_c1"}, 32'(stall), 32'd0);
    step();
    chk({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, "_no_req_c2"}, 32'(mif.mem_req), 32'd0);
  endtask
`endif

  initial begin
    mif.mem_ack = 1'b0;
    mif.mem_rdata = 32'h0;

    //           op      addr          wdata         a3     k    rdata         we    be       addr          wdata         rdata
    vecs[0]  = '{OP_SW,  32'h0000_0100, 32'h1234_5678, 5'd3,  1, 32'h0,        1'b1, 4'b1111, 32'h0000_0100, 32'h1234_5678, 32'h0};
    vecs[1]  = '{OP_SB,  32'h0000_0103, 32'h0000_00AB, 5'd0,  2, 32'h0,        1'b1, 4'b1000, 32'h0000_0100, 32'hABAB_ABAB, 32'h0};
    vecs[2]  = '{OP_LB,  32'h0000_0103, 32'h0,         5'd5,  1, 32'hAB00_0000, 1'b0, 4'b0000, 32'h0000_0100, 32'h0,         32'hFFFF_FFAB};
    vecs[3]  = '{OP_LBU, 32'h0000_0103, 32'h0,         5'd6,  1, 32'hAB00_0000, 1'b0, 4'b0000, 32'h0000_0100, 32'h0,         32'h0000_00AB};
    vecs[4]  = '{OP_LH,  32'h0000_0102, 32'h0,         5'd7,  5, 32'h8001_FFFF, 1'b0, 4'b0000, 32'h0000_0100, 32'h0,         32'hFFFF_8001};
    vecs[5]  = '{OP_LHU, 32'h0000_0102, 32'h0,         5'd8,  1, 32'h8001_FFFF, 1'b0, 4'b0000, 32'h0000_0100, 32'h0,         32'h0000_8001};
    vecs[6]  = '{OP_SH,  32'h0000_0102, 32'hCAFE_BEEF, 5'd1,  1, 32'h0,        1'b1, 4'b1100, 32'h0000_0100, 32'hBEEF_BEEF, 32'h0};
    vecs[7]  = '{OP_SB,  32'h0000_0101, 32'h0000_0055, 5'd2,  3, 32'h0,        1'b1, 4'b0010, 32'h0000_0100, 32'h5555_5555, 32'h0};
    vecs[8]  = '{OP_LW,  32'h0000_0200, 32'h0,         5'd31, 1, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF};
    vecs[9]  = '{OP_LB,  32'h0000_0001, 32'h0,         5'd10, 1, 32'h0000_7F00, 1'b0, 4'b0000, 32'h0000_0000, 32'h0,         32'h0000_007F};
    vecs[10] = '{OP_LH,  32'h0000_0000, 32'h0,         5'd11, 1, 32'h1234_ABCD, 1'b0, 4'b0000, 32'h0000_0000, 32'h0,         32'hFFFF_ABCD};
    // Ack arrives in the last cycle before the timeout would fire
    vecs[11] = '{OP_SH,  32'h0000_0400, 32'h0000_1234, 5'd12, TO, 32'h0,       1'b1, 4'b0011, 32'h0000_0400, 32'h1234_1234, 32'h0};

    repeat (3) step();
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_exc_valid", 32'(exc_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_be", 32'(mif.mem_be), 32'd0);
    chk("rst_addr", mif.mem_addr, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

`ifdef LSU_ALIGN_CHECK_EN
    run_fault(OP_LW, 32'h0000_0101, EXC_ADEL, "align_lw");
    run_fault(OP_SH, 32'h0000_0001, EXC_ADES, "align_sh");
    run_fault(OP_LHU, 32'h0000_0203, EXC_ADEL, "align_lhu");
`else
    run_vec('{OP_LW, 32'h0000_0101, 32'h0, 5'd4, 1, 32'h1122_3344, 1'b0, 4'b0000,
              32'h0000_0100, 32'h0, 32'h1122_3344}, "unaligned_lw");
`endif

    // Stray acks while idle must not produce a completion
    step();
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h5A5A_5A5A;
    step();
    #1;
    chk("stray_ack_resp", 32'(resp_valid), 32'd0);
    chk("stray_ack_req", 32'(mif.mem_req), 32'd0);
    mif.mem_ack = 1'b0;

    // Timeout: no ack at all
    step();
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_0800; req_a3 = 5'd13;
    for (int c = 1; c <= TO; c++) begin
      step();
      #1;
      chk($sformatf("to_req_c%0d", c), 32'(mif.mem_req), 32'd1);
      chk($sformatf("to_noresp_c%0d", c), 32'(resp_valid), 32'd0);
    end
    step();
    req_valid = 1'b0;
    #1;
    chk("to_resp_valid", 32'(resp_valid), 32'd1);
    chk("to_exc_valid", 32'(exc_valid), 32'd1);
    chk("to_exc_code", 32'(exc_code), 32'd7);
    chk("to_rdata", resp_rdata, 32'd0);
    chk("to_a3", 32'(resp_a3), 32'd0);
    chk("to_req_drop", 32'(mif.mem_req), 32'd0);
    chk("to_stall", 32'(stall), 32'd0);

    // Reset in the middle of an access abandons it
    step();
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_0300; req_a3 = 5'd14;
    step();
    #1;
    chk("rb_req_c1", 32'(mif.mem_req), 32'd1);
    step();
    reset = 1'b1; req_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("rb_req_drop", 32'(mif.mem_req), 32'd0);
    chk("rb_stall", 32'(stall), 32'd0);
    chk("rb_no_resp", 32'(resp_valid), 32'd0);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
    step();
    mif.mem_ack = 1'b0;
    #1;
    chk("rb_late_ack_resp", 32'(resp_valid), 32'd0);
    chk("rb_late_ack_req", 32'(mif.mem_req), 32'd0);
    step();
    chk("rb_late_ack_resp2", 32'(resp_valid), 32'd0);

    // A normal access still works after the abandoned one
    run_vec(vecs[8], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_master.md
# lsu_master

Load/store initiator in the MEM stage of the pipelined MIPS core: accepts one load or store per instruction from the pipeline and drives a word-wide request/acknowledge memory port. Handles byte lane steering, byte enables and load sign/zero extension, and stalls the pipeline until the memory side responds. This is the master side of the data memory interface, replacing direct combinational memory reads with a handshaked access that supports multi-cycle memories.

## Interface
- TIMEOUT, 64: max BUSY cycles waiting for mem_ack before a bus error (1..255).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  pipeline presents a memory op; held stable while stall=1.
- req_op  in  3  operation code (package enum).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_a3  in  5  destination register, passed through to resp_a3.
- stall  out  1  hold MEM stage and earlier.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_a3  out  5  latched req_a3.
- exc_valid  out  1  exception with this completion.
- exc_code  out  5  4=AdEL, 5=AdES, 7=DBE.
- mem_req  out  1  request to memory.
- mem_we  out  1  1=write.
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}.
- mem_be  out  4  byte enables (writes only; 4'b0000 on reads).
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory accepted/completed; mem_rdata valid same cycle.
- mem_rdata  in  32  read word.

## Operation
- Ops: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- FSM states IDLE, BUSY, RESP.
- IDLE: on req_valid latch op, addr, wdata, a3; go BUSY. If alignment fault (see Configuration) go RESP directly with exception, no memory access.
- BUSY: mem_req=1 with registered mem_we/mem_addr/mem_be/mem_wdata stable. On mem_ack: capture mem_rdata, go RESP. Counter increments each BUSY cycle without ack; on reaching TIMEOUT drop mem_req, go RESP with exc_code=7.
- RESP: resp_valid=1 one cycle; return IDLE. Next request may be accepted in the following IDLE cycle.
- stall = (IDLE && req_valid) || BUSY. Low in RESP, so pipeline advances exactly on the resp_valid cycle.
- Store steering: SW be=1111 data=wdata; SH be=addr[1]?1100:0011 data={2{wdata[15:0]}}; SB be=0001<<addr[1:0] data={4{wdata[7:0]}}.
- Load extract from captured word: LB/LBU byte addr[1:0]; LH/LHU half addr[1]; sign-extend LB/LH, zero-extend LBU/LHU; LW whole word.
- Exception completions: resp_rdata=0, resp_a3=0 (no writeback).
- Illegal: none; all 8 codes defined.

## Timing
- Reset values: state IDLE, all outputs 0, counter 0.
- Accept cycle 0 (IDLE), mem_req from cycle 1; ack in cycle k≥1, resp_valid in cycle k+1. Minimum latency 2 cycles, stall high 2 cycles.
- mem_ack outside BUSY ignored.
- Reset mid-BUSY: mem_req drops at that edge; outstanding access abandoned, no resp_valid.
- Alignment fault: resp_valid+exc_valid in cycle 1, stall high cycle 0 only.
- Timeout: with no ack, mem_req high cycles 1..TIMEOUT, resp_valid/exc_valid in cycle TIMEOUT+1.

## Configuration
- LSU_ALIGN_CHECK_EN defined: LW/SW with addr[1:0]≠0, LH/LHU/SH with addr[0]=1 raise AdEL (loads) or AdES (stores); no memory access.
- Undefined: no alignment exceptions; low address bits ignored per steering rules (LW uses word, LH uses addr[1]). exc_code 7 still possible.

## Structure
- Shared package/header: op encoding constants, FSM state encoding, exception codes 4/5/7.
- One sub-module lsu_lane: combinational store steering (be, wdata) and load extraction; FSM, counter and registers in lsu_master.

## Test plan
- SW addr 0x100 data 0x12345678, ack in cycle 1 -> mem_be=1111, mem_addr=0x100, resp_valid cycle 2, stall high cycles 0-1.
- SB addr 0x103 data 0xAB -> mem_be=1000, mem_wdata=0xABABABAB; then LB 0x103 with mem_rdata=0xAB000000 -> resp_rdata=0xFFFFFFAB; LBU -> 0x000000AB.
- LH 0x102 mem_rdata 0x8001FFFF -> 0xFFFF8001; LHU -> 0x00008001; ack delayed 5 cycles -> stall held, resp_valid in cycle 6.
- LSU_ALIGN_CHECK_EN: LW 0x101 -> exc_code 4, no mem_req; SH 0x001 -> exc_code 5. Without macro: LW 0x101 reads word 0x100.
- No ack, TIMEOUT=4 -> mem_req cycles 1-4, exc_code 7 in cycle 5.
- Reset asserted in BUSY -> next cycle mem_req=0, state IDLE, no resp_valid; later mem_ack ignored.
